// File: rtl/fetch_controller.sv
// fetch_controller: dual-issue instruction fetch sequencer.
// Owns the PC, drives two combinational instruction-memory read ports
// (pc and pc+4) and queues fetched instruction/PC pairs in a small FIFO
// that decode drains 0..2 entries per cycle. Redirects flush and restart.
// Optional build macro: FETCH_PERF_EN adds saturating perf counters.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 56,
  parameter int          DEPTH     = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] addr1_o,
  output logic [31:0] addr2_o,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [1:0]  take_i,
  output logic        inst0_valid_o,
  output logic        inst1_valid_o,
  output logic [31:0] inst0_o,
  output logic [31:0] inst1_o,
  output logic [31:0] pc0_o,
  output logic [31:0] pc1_o,
  output logic        halted_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int          PTR_W     = $clog2(DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [31:0] PAIR_LAST = MEM_BYTES - 32'd8;
  localparam logic [31:0] LAST_WORD = MEM_BYTES - 32'd4;
  localparam logic [CNT_W-1:0] CNT_PAIR_MAX   = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] CNT_SINGLE_MAX = CNT_W'(DEPTH - 1);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       instMem_q [DEPTH];
  logic [31:0]       pcMem_q   [DEPTH];

  logic              fetchEn;
  logic              canPair;
  logic              canSingle;
  logic [CNT_W-1:0]  pushNum;
  logic [CNT_W-1:0]  popNum;
  logic [CNT_W-1:0]  takeEff;
  logic [31:0]       pcStep;
  logic [31:0]       redirectTarget;
  logic [PTR_W-1:0]  rdPtrNext;
  logic              unusedBits;

  assign redirectTarget = {redirect_pc_i[31:2], 2'b00};
  assign unusedBits     = ^redirect_pc_i[1:0];

  // State register for the RUN/HALT sequencer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: redirect picks the state from its target, otherwise halt once the PC leaves memory
  always_comb begin
    state_d = state_q;
    if (redirect_valid_i) begin
      state_d = (redirectTarget >= MEM_BYTES) ? HALT : RUN;
    end else if (state_q == RUN && pc_d >= MEM_BYTES) begin
      state_d = HALT;
    end
  end

  // FSM outputs: fetching is only allowed while running
  always_comb begin
    fetchEn  = (state_q == RUN);
    halted_o = (state_q == HALT);
  end

  // Fetch/pop decision uses pre-pop occupancy so take never reaches the address or push path
  always_comb begin
    canPair   = fetchEn && (pc_q <= PAIR_LAST) && (count_q <= CNT_PAIR_MAX);
    canSingle = fetchEn && (pc_q == LAST_WORD) && (count_q <= CNT_SINGLE_MAX);
    pushNum   = '0;
    pcStep    = 32'd0;
    if (!redirect_valid_i) begin
      if (canPair) begin
        pushNum = CNT_W'(2);
        pcStep  = 32'd8;
      end else if (canSingle) begin
        pushNum = CNT_W'(1);
        pcStep  = 32'd4;
      end
    end
    takeEff = (take_i > 2'd2) ? CNT_W'(2) : CNT_W'(take_i);
    popNum  = '0;
    if (!redirect_valid_i) begin
      popNum = (takeEff > count_q) ? count_q : takeEff;
    end
  end

  // Next values for PC, pointers and occupancy; redirect flushes and reloads
  always_comb begin
    if (redirect_valid_i) begin
      pc_d    = redirectTarget;
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      pc_d    = pc_q + pcStep;
      rdPtr_d = rdPtr_q + PTR_W'(popNum);
      wrPtr_d = wrPtr_q + PTR_W'(pushNum);
      count_d = count_q + pushNum - popNum;
    end
  end

  // PC and FIFO bookkeeping registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q    <= RESET_PC;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage: first push takes port 1, second push takes port 2
  always_ff @(posedge clk_i) begin
    if (pushNum != '0) begin
      instMem_q[wrPtr_q] <= data1_i;
      pcMem_q[wrPtr_q]   <= pc_q;
    end
    if (pushNum == CNT_W'(2)) begin
      instMem_q[wrPtr_q + PTR_W'(1)] <= data2_i;
      pcMem_q[wrPtr_q + PTR_W'(1)]   <= pc_q + 32'd4;
    end
  end

  // Memory addresses follow the PC at all times; head outputs are zero when their slot is empty
  always_comb begin
    addr1_o       = pc_q;
    addr2_o       = pc_q + 32'd4;
    rdPtrNext     = rdPtr_q + PTR_W'(1);
    inst0_valid_o = (count_q != '0);
    inst1_valid_o = (count_q >= CNT_W'(2));
    inst0_o       = inst0_valid_o ? instMem_q[rdPtr_q]   : 32'd0;
    pc0_o         = inst0_valid_o ? pcMem_q[rdPtr_q]     : 32'd0;
    inst1_o       = inst1_valid_o ? instMem_q[rdPtrNext] : 32'd0;
    pc1_o         = inst1_valid_o ? pcMem_q[rdPtrNext]   : 32'd0;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched_q;
  logic [31:0] perfStall_q;

  // Saturating counters of pushed instructions and RUN cycles that fetched nothing
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perfFetched_q <= 32'd0;
      perfStall_q   <= 32'd0;
    end else begin
      if (perfFetched_q > (32'hFFFF_FFFF - 32'(pushNum))) begin
        perfFetched_q <= 32'hFFFF_FFFF;
      end else begin
        perfFetched_q <= perfFetched_q + 32'(pushNum);
      end
      if (fetchEn && !redirect_valid_i && pushNum == '0 && perfStall_q != 32'hFFFF_FFFF) begin
        perfStall_q <= perfStall_q + 32'd1;
      end
    end
  end

  assign perf_fetched_o = perfFetched_q;
  assign perf_stall_o   = perfStall_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios followed by
// randomized take/redirect traffic, all compared against a queue-based model.
module tb_fetch_controller;

  localparam int          MEM_WORDS = 56;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] addr1_o, addr2_o, data1_i, data2_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [1:0]  take_i;
  logic        inst0_valid_o, inst1_valid_o;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic        halted_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_o, perf_stall_o;
`endif

  logic [31:0] imem [MEM_WORDS];
  entry_t      q [$];
  logic [31:0] mPc;
  logic        mHalt;
  logic [31:0] mFetched;
  logic [31:0] mStall;
  int          checks = 0;
  int          errors = 0;

  // Instruction memory model: in-range words are random, beyond the end a recognisable pattern
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if ((addr >> 2) < 32'(MEM_WORDS)) return imem[addr >> 2];
    return addr ^ 32'hA5A5_0000;
  endfunction

  assign data1_i = memWord(addr1_o);
  assign data2_i = memWord(addr2_o);

  fetch_controller #(
    .RESET_PC (RESET_PC),
    .MEM_WORDS(MEM_WORDS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .addr1_o         (addr1_o),
    .addr2_o         (addr2_o),
    .data1_i         (data1_i),
    .data2_i         (data2_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .take_i          (take_i),
    .inst0_valid_o   (inst0_valid_o),
    .inst1_valid_o   (inst1_valid_o),
    .inst0_o         (inst0_o),
    .inst1_o         (inst1_o),
    .pc0_o           (pc0_o),
    .pc1_o           (pc1_o),
    .halted_o        (halted_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o  (perf_fetched_o),
    .perf_stall_o    (perf_stall_o)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Model returned to its post-reset condition
  task automatic modelReset();
    q.delete();
    mPc      = RESET_PC;
    mHalt    = 1'b0;
    mFetched = 32'd0;
    mStall   = 32'd0;
  endtask

  // One clock edge of the reference behaviour: pops from the old head, then appends fetched words
  task automatic modelStep(input logic [1:0] tk, input logic rv, input logic [31:0] rpc);
    int cnt;
    int nPop;
    int nPush;
    cnt   = q.size();
    nPush = 0;
    if (rv) begin
      q.delete();
      mPc   = {rpc[31:2], 2'b00};
      mHalt = (mPc >= MEM_BYTES);
    end else begin
      if (!mHalt) begin
        if (mPc + 32'd8 <= MEM_BYTES && cnt <= DEPTH - 2) nPush = 2;
        else if (mPc + 32'd4 == MEM_BYTES && cnt <= DEPTH - 1) nPush = 1;
        if (nPush == 0) mStall = mStall + 32'd1;
      end
      nPop = (int'(tk) < cnt) ? int'(tk) : cnt;
      repeat (nPop) void'(q.pop_front());
      for (int i = 0; i < nPush; i++) begin
        q.push_back('{inst: memWord(mPc), pc: mPc});
        mPc = mPc + 32'd4;
      end
      mFetched = mFetched + 32'(nPush);
      if (mPc >= MEM_BYTES) mHalt = 1'b1;
    end
  endtask

  // Compare every observable output with the model
  task automatic compareAll(input string where);
    checkOutput({where, ":addr1"}, addr1_o, mPc);
    checkOutput({where, ":addr2"}, addr2_o, mPc + 32'd4);
    checkOutput({where, ":v0"}, 32'(inst0_valid_o), 32'(q.size() >= 1));
    checkOutput({where, ":v1"}, 32'(inst1_valid_o), 32'(q.size() >= 2));
    checkOutput({where, ":inst0"}, inst0_o, (q.size() >= 1) ? q[0].inst : 32'd0);
    checkOutput({where, ":pc0"}, pc0_o, (q.size() >= 1) ? q[0].pc : 32'd0);
    checkOutput({where, ":inst1"}, inst1_o, (q.size() >= 2) ? q[1].inst : 32'd0);
    checkOutput({where, ":pc1"}, pc1_o, (q.size() >= 2) ? q[1].pc : 32'd0);
    checkOutput({where, ":halted"}, 32'(halted_o), 32'(mHalt));
`ifdef FETCH_PERF_EN
    checkOutput({where, ":perfFetched"}, perf_fetched_o, mFetched);
    checkOutput({where, ":perfStall"}, perf_stall_o, mStall);
`endif
  endtask

  // Drive one cycle of inputs, advance model and DUT across an edge, then compare
  task automatic applyStimulus(input string where, input logic [1:0] tk, input logic rv, input logic [31:0] rpc);
    take_i           = tk;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    modelStep(tk, rv, rpc);
    @(posedge clk_i);
    #1;
    compareAll(where);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge
  task automatic midReset(input string where);
    #2 reset_i = 1'b1;
    #1;
    modelReset();
    compareAll(where);
    checkOutput({where, ":addr2Reset"}, addr2_o, RESET_PC + 32'd4);
    #1 reset_i = 1'b0;
  endtask

  // Test sequence: directed scenarios then randomized traffic
  initial begin
    logic [1:0]  tk;
    logic        rv;
    logic [31:0] rpc;
    for (int i = 0; i < MEM_WORDS; i++) imem[i] = $urandom;
    take_i           = 2'd0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'd0;
    reset_i          = 1'b0;
    modelReset();
    #1 reset_i = 1'b1;
    #8;
    compareAll("reset");
    @(negedge clk_i);
    reset_i = 1'b0;

    applyStimulus("fill1", 2'd0, 1'b0, 32'd0);
    applyStimulus("fill2", 2'd0, 1'b0, 32'd0);
    checkOutput("planPc0", pc0_o, 32'd0);
    checkOutput("planPc1", pc1_o, 32'd4);
    checkOutput("planPc", addr1_o, 32'd16);
    applyStimulus("fill3", 2'd0, 1'b0, 32'd0);
    checkOutput("planFullHold", addr1_o, 32'd16);

    for (int i = 0; i < 35; i++) applyStimulus("stream", 2'd2, 1'b0, 32'd0);
    checkOutput("streamHalted", 32'(halted_o), 32'd1);
    checkOutput("streamDrained", 32'(inst0_valid_o), 32'd0);

    applyStimulus("tailRedir", 2'd0, 1'b1, 32'd220);
    applyStimulus("tailPush", 2'd0, 1'b0, 32'd0);
    checkOutput("tailPc0", pc0_o, 32'd220);
    checkOutput("tailV1", 32'(inst1_valid_o), 32'd0);
    checkOutput("tailHalt", 32'(halted_o), 32'd1);

    applyStimulus("refill0", 2'd0, 1'b1, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus("refill", 2'd0, 1'b0, 32'd0);
    applyStimulus("flushRedir", 2'd2, 1'b1, 32'd64);
    checkOutput("flushEmpty", 32'(inst0_valid_o), 32'd0);
    checkOutput("flushAddr", addr1_o, 32'd64);
    applyStimulus("flushTarget", 2'd0, 1'b0, 32'd0);
    checkOutput("flushPc0", pc0_o, 32'd64);

    applyStimulus("farRedir", 2'd1, 1'b1, 32'h101);
    checkOutput("farPc", addr1_o, 32'h100);
    checkOutput("farHalt", 32'(halted_o), 32'd1);
    applyStimulus("farIdle1", 2'd0, 1'b0, 32'd0);
    applyStimulus("farIdle2", 2'd0, 1'b0, 32'd0);
    applyStimulus("farResume", 2'd0, 1'b1, 32'd0);
    checkOutput("resumeRun", 32'(halted_o), 32'd0);

    for (int i = 0; i < 5; i++) applyStimulus("preReset", 2'd1, 1'b0, 32'd0);
    midReset("midReset1");

    for (int i = 0; i < 600; i++) begin
      tk  = 2'($urandom_range(0, 2));
      rv  = ($urandom_range(0, 11) == 0);
      rpc = $urandom_range(0, int'(MEM_BYTES) + 40);
      applyStimulus("random", tk, rv, rpc);
      if (i == 300) midReset("midReset2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
